// File: rtl/dmem_banked.sv
// rtl/dmem_banked.sv - byte-addressable data memory with fixed read latency
// Optional DMEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors.
module dmem_banked #(
    parameter int ADDR_W   = 17,
    parameter int READ_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);
    localparam int         DEPTH    = 1 << (ADDR_W - 2);
    localparam logic [1:0] CNT_LAST = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;
    logic [31:0]        pend_data_q, pend_data_d;
    logic               pend_err_q, pend_err_d;
    logic               rsp_valid_q;
    logic [31:0]        rsp_rdata_q;
    logic               rsp_err_q;

    logic [31:0]        mem [DEPTH];
    logic               accept;
    logic [ADDR_W-3:0]  widx;
    logic [1:0]         lane;
    logic               misalign;
    logic               acc_err;
    logic [3:0]         be;
    logic [31:0]        wword;
    logic [31:0]        rword;
    logic [31:0]        ld_data;
    logic [7:0]         ld_byte;
    logic [15:0]        ld_half;

    assign req_ready = rst_n && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign widx      = req_addr[ADDR_W-1:2];
    assign lane      = req_addr[1:0];
    assign rword     = mem[widx];

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = ((req_size == 2'b01) && lane[0]) ||
                      ((req_size == 2'b10) && (lane != 2'b00));
`else
    assign misalign = 1'b0;
`endif
    assign acc_err = (req_size == 2'b11) || misalign;

    // Misaligned accesses fall through here force-aligned: half uses lane[1] only.
    always_comb begin
        be      = 4'b1111;
        wword   = req_wdata;
        ld_byte = rword[{lane, 3'b000} +: 8];
        ld_half = lane[1] ? rword[31:16] : rword[15:0];
        ld_data = rword;
        case (req_size)
            2'b00: begin
                be      = 4'b0001 << lane;
                wword   = {4{req_wdata[7:0]}};
                ld_data = {{24{ld_byte[7] & ~req_unsigned}}, ld_byte};
            end
            2'b01: begin
                be      = lane[1] ? 4'b1100 : 4'b0011;
                wword   = {2{req_wdata[15:0]}};
                ld_data = {{16{ld_half[15] & ~req_unsigned}}, ld_half};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept && req_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mem[widx][8*i +: 8] <= wword[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_data_d = pend_data_q;
        pend_err_d  = pend_err_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    pend_data_d = (req_we || acc_err) ? 32'd0 : ld_data;
                    pend_err_d  = acc_err;
                    cnt_d       = 2'd1;
                    state_d     = (READ_LAT == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 2'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            pend_data_q <= 32'd0;
            pend_err_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'd0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_data_q <= pend_data_d;
            pend_err_q  <= pend_err_d;
            rsp_valid_q <= (state_q == RESP);
            rsp_rdata_q <= (state_q == RESP) ? pend_data_q : 32'd0;
            rsp_err_q   <= (state_q == RESP) && pend_err_q;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_dmem_banked.sv
// tb/tb_dmem_banked.sv - vector and random checks of dmem_banked at READ_LAT 1, 2 and 3
module tb_dmem_banked;
`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst2_n = 1'b0;
    logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  sz = 2'b00;
    logic        uns = 1'b0;
    logic [16:0] addr = '0;
    logic [31:0] wd = '0;
    logic        rdy1, rdy2, rdy3, rv1, rv2, rv3, er1, er2, er3;
    logic [31:0] rd1, rd2, rd3;

    int n_chk = 0;
    int n_fail = 0;

    logic [7:0] mm [int];

    typedef struct {
        string       nm;
        bit          we;
        logic [1:0]  sz;
        bit          uns;
        logic [16:0] addr;
        logic [31:0] wd;
        logic [31:0] erd;
        bit          eerr;
    } vec_t;
    vec_t tv[$];

    always #5 clk = ~clk;

    dmem_banked #(.ADDR_W(17), .READ_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_we(we),
        .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wd),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(er1));
    dmem_banked #(.ADDR_W(17), .READ_LAT(2)) u_dut2 (
        .clk(clk), .rst_n(rst2_n), .req_valid(v2), .req_ready(rdy2), .req_we(we),
        .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wd),
        .rsp_valid(rv2), .rsp_rdata(rd2), .rsp_err(er2));
    dmem_banked #(.ADDR_W(17), .READ_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_ready(rdy3), .req_we(we),
        .req_size(sz), .req_unsigned(uns), .req_addr(addr), .req_wdata(wd),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input string nm, input bit w, input logic [1:0] s, input bit u,
                                input logic [16:0] a, input logic [31:0] d,
                                input logic [31:0] erd, input bit eerr);
        vec_t v;
        v.nm = nm; v.we = w; v.sz = s; v.uns = u; v.addr = a; v.wd = d;
        v.erd = erd; v.eerr = eerr;
        return v;
    endfunction

    // Byte-level reference: little-endian bytes, aligned down to the access size.
    task automatic model(input bit w, input logic [1:0] s, input bit u, input int a,
                         input logic [31:0] d, output logic [31:0] rd, output bit e);
        int n, ea;
        rd = 32'd0;
        e  = 1'b0;
        if (s == 2'b11) begin
            e = 1'b1;
        end else begin
            n = 1 << s;
            if (TRAP && (a % n) != 0) begin
                e = 1'b1;
            end else begin
                ea = a - (a % n);
                for (int i = 0; i < n; i++) begin
                    if (w) mm[ea + i] = 8'(d >> (8 * i));
                    else   rd = rd | (32'(mm[ea + i]) << (8 * i));
                end
                if (!w && !u && n < 4 && rd[8*n-1]) rd = rd | (32'hFFFF_FFFF << (8 * n));
            end
        end
    endtask

    task automatic req1(input bit w, input logic [1:0] s, input bit u, input logic [16:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic e);
        int n;
        @(negedge clk);
        we = w; sz = s; uns = u; addr = a; wd = d; v1 = 1'b1;
        n = 0;
        while (!rdy1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_ready_idle", 32'(rdy1), 1);
        @(posedge clk); #1;
        v1 = 1'b0;
        chk("rsp_early", 32'(rv1), 0);
        chk("rdata_when_idle", rd1, 0);
        chk("ready_busy", 32'(rdy1), 0);
        @(posedge clk); #1;
        chk("rsp_valid", 32'(rv1), 1);
        rd = rd1;
        e  = er1;
        @(posedge clk); #1;
        chk("rsp_pulse_width", 32'(rv1), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] got_rd, exp_rd;
        logic        got_e;
        bit          exp_e;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", 32'(rdy1), 0);
        chk("reset_rsp_valid", 32'(rv1), 0);
        chk("reset_rdata", rd1, 0);
        chk("reset_err", 32'(er1), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        rst2_n = 1'b1;

        tv.push_back(mk("st_w_4",      1, 2'b10, 0, 17'h04, 32'h5000_0009, 32'h0, 0));
        tv.push_back(mk("ld_w_4",      0, 2'b10, 0, 17'h04, 32'h0, 32'h5000_0009, 0));
        tv.push_back(mk("st_b_6",      1, 2'b00, 0, 17'h06, 32'h0000_00AB, 32'h0, 0));
        tv.push_back(mk("ld_b_s_6",    0, 2'b00, 0, 17'h06, 32'h0, 32'hFFFF_FFAB, 0));
        tv.push_back(mk("ld_b_u_6",    0, 2'b00, 1, 17'h06, 32'h0, 32'h0000_00AB, 0));
        tv.push_back(mk("ld_w_4b",     0, 2'b10, 0, 17'h04, 32'h0, 32'h50AB_0009, 0));
        tv.push_back(mk("st_w_10",     1, 2'b10, 0, 17'h10, 32'h1122_3344, 32'h0, 0));
        tv.push_back(mk("st_h_12",     1, 2'b01, 0, 17'h12, 32'h0000_8001, 32'h0, 0));
        tv.push_back(mk("ld_h_s_12",   0, 2'b01, 0, 17'h12, 32'h0, 32'hFFFF_8001, 0));
        tv.push_back(mk("ld_h_u_10",   0, 2'b01, 1, 17'h10, 32'h0, 32'h0000_3344, 0));
        tv.push_back(mk("ld_w_10",     0, 2'b10, 1, 17'h10, 32'h0, 32'h8001_3344, 0));
        tv.push_back(mk("st_w_8",      1, 2'b10, 0, 17'h08, 32'h0000_0000, 32'h0, 0));
        tv.push_back(mk("st_w_9_mis",  1, 2'b10, 0, 17'h09, 32'hDEAD_BEEF, 32'h0, TRAP));
        tv.push_back(mk("ld_w_8",      0, 2'b10, 0, 17'h08, 32'h0, TRAP ? 32'h0 : 32'hDEAD_BEEF, 0));
        tv.push_back(mk("ld_rsvd",     0, 2'b11, 0, 17'h04, 32'h0, 32'h0, 1));
        tv.push_back(mk("st_rsvd",     1, 2'b11, 0, 17'h04, 32'hFFFF_FFFF, 32'h0, 1));
        tv.push_back(mk("ld_w_4c",     0, 2'b10, 0, 17'h04, 32'h0, 32'h50AB_0009, 0));
        tv.push_back(mk("ld_h_u_13",   0, 2'b01, 1, 17'h13, 32'h0, TRAP ? 32'h0 : 32'h0000_8001, TRAP));

        foreach (tv[i]) begin
            req1(tv[i].we, tv[i].sz, tv[i].uns, tv[i].addr, tv[i].wd, got_rd, got_e);
            chk({tv[i].nm, "_rdata"}, got_rd, tv[i].erd);
            chk({tv[i].nm, "_err"}, 32'(got_e), 32'(tv[i].eerr));
        end

        // READ_LAT=3 with req_valid held: accepts every 4 cycles, response 3 after each.
        @(negedge clk);
        we = 1'b1; sz = 2'b10; uns = 1'b0; addr = 17'h20; wd = 32'h0; v3 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            chk("lat3_ready", 32'(rdy3), 32'((i % 4) == 0));
            chk("lat3_rsp_valid", 32'(rv3), 32'(((i % 4) == 0) && (i > 0)));
            @(negedge clk);
        end
        v3 = 1'b0;
        repeat (4) @(negedge clk);

        // READ_LAT=2 load aborted by reset on the following cycle.
        we = 1'b0; sz = 2'b10; addr = 17'h04; v2 = 1'b1;
        #1;
        chk("lat2_ready", 32'(rdy2), 1);
        @(posedge clk); #1;
        v2 = 1'b0;
        @(negedge clk);
        rst2_n = 1'b0;
        #1;
        chk("lat2_ready_in_reset", 32'(rdy2), 0);
        @(posedge clk); #1;
        chk("lat2_no_rsp_reset_edge", 32'(rv2), 0);
        @(negedge clk);
        rst2_n = 1'b1;
        #1;
        chk("lat2_ready_after_reset", 32'(rdy2), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("lat2_no_rsp_after_reset", 32'(rv2), 0);
        end

        // Random traffic in a pre-initialised window against the byte model.
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model(1'b1, 2'b10, 1'b0, 32'h100 + 4 * i, wd, exp_rd, exp_e);
            req1(1'b1, 2'b10, 1'b0, 17'(32'h100 + 4 * i), wd, got_rd, got_e);
            chk("init_err", 32'(got_e), 0);
        end
        for (int i = 0; i < 60; i++) begin
            bit          w, u;
            logic [1:0]  s;
            int          a;
            logic [31:0] d;
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            s = 2'($urandom_range(0, 3));
            a = 32'h100 + int'($urandom_range(0, 63));
            d = $urandom;
            model(w, s, u, a, d, exp_rd, exp_e);
            req1(w, s, u, 17'(a), d, got_rd, got_e);
            chk("rand_rdata", got_rd, exp_rd);
            chk("rand_err", 32'(got_e), 32'(exp_e));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
